// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath width, ALU op-class selectors, funct3
// encodings for the base ALU and the M extension, and the mul/div FSM state.
package cpu_defs;

    localparam int XLEN = 32;

    // ex_alusel op classes
    localparam logic [2:0] ALUSEL_NOP       = 3'd0;
    localparam logic [2:0] ALUSEL_LOGIC     = 3'd1;
    localparam logic [2:0] ALUSEL_SHIFT     = 3'd2;
    localparam logic [2:0] ALUSEL_ARITH     = 3'd3;
    localparam logic [2:0] ALUSEL_MULDIV    = 3'd4;
    localparam logic [2:0] ALUSEL_LOADSTORE = 3'd5;

    // RV32I funct3 (SUB/SRA share ADD/SRL and are picked by funct7[5])
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // RV32M funct3
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one step per clock over MD_STEPS cycles.
// Ports:
//   clk, rst_n (sync, active-low), flush (abort, back to IDLE)
//   start      : a mul/div op is presented (only sampled in IDLE)
//   op         : M-extension funct3
//   a, b       : operands (held stable by upstream while busy)
//   busy       : unit needs the pipeline held this cycle
//   done       : result is valid this cycle (DONE state)
//   result     : final 32-bit result
module muldiv_iter #(
    parameter int XLEN     = 32,
    parameter int MD_STEPS = 32   // must equal XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import cpu_defs::*;

    localparam int CW = $clog2(MD_STEPS);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;     // mul: {hi, multiplier}; div: {rem, quotient}
    logic [XLEN-1:0]   opnd_q, opnd_d;   // mul: multiplicand; div: divisor
    logic [XLEN-1:0]   res_q, res_d;
    logic [2:0]        op_q, op_d;
    logic              sa_q, sa_d, sb_q, sb_d;

    // operand sign handling at start
    logic            sgn_a, sgn_b, sa, sb, is_div, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special;

    assign is_div   = op[2];
    assign sgn_a    = (op != F3_MULHU) && (op != F3_DIVU) && (op != F3_REMU);
    assign sgn_b    = (op == F3_MUL) || (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
    assign sa       = sgn_a & a[XLEN-1];
    assign sb       = sgn_b & b[XLEN-1];
    assign a_mag    = sa ? -a : a;
    assign b_mag    = sb ? -b : b;
    assign div_zero = (b == '0);
    assign div_ovf  = ((op == F3_DIV) || (op == F3_REM)) && (a == INT_MIN) && (b == '1);
    // op[1] distinguishes REM/REMU from DIV/DIVU
    assign special  = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : INT_MIN);

    // one iteration
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_next, div_next, step_next, prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    // trial subtract of divisor from {partial remainder, next dividend bit}
    assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    assign div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign step_next = op_q[2] ? div_next : mul_next;

    // sign correction on the last step
    assign prod = (sa_q ^ sb_q) ? -step_next : step_next;
    assign quo  = (sa_q ^ sb_q) ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
    assign rem  = sa_q ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];

    always_comb begin
        final_res = '0;
        if (op_q[2])
            final_res = op_q[1] ? rem : quo;
        else
            final_res = (op_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    op_d = op;
                    sa_d = sa;
                    sb_d = sb;
                    if (is_div && (div_zero || div_ovf)) begin
                        res_d   = special;
                        state_d = MD_DONE;
                    end else begin
                        opnd_d  = is_div ? b_mag : a_mag;
                        acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        cnt_d   = '0;
                        state_d = MD_BUSY;
                    end
                end
            end
            MD_BUSY: begin
                acc_d = step_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(MD_STEPS-1)) begin
                    res_d   = final_res;
                    state_d = MD_DONE;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (flush) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
        end
    end

    assign busy   = (state_q == MD_BUSY) || ((state_q == MD_IDLE) && start);
    assign done   = (state_q == MD_DONE);
    assign result = res_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage with integrated EX/MEM register. Single-cycle RV32I ALU plus
// an iterative mul/div unit that stalls the pipeline while it works.
// Ports:
//   clk, rst_n (sync, active-low), flush (kill instruction in EX)
//   ex_*     : decoded instruction from the ID/EX register
//   stallreq : hold ID/EX and upstream (combinational)
//   mem_*    : registered outputs to the MEM stage
module ex_stage #(
    parameter int XLEN     = 32,
    parameter int MD_STEPS = 32   // must equal XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [6:0]      ex_aluop,
    input  logic [2:0]      ex_alusel,
    input  logic [XLEN-1:0] ex_reg1,
    input  logic [XLEN-1:0] ex_reg2,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [4:0]      ex_wd,
    input  logic            ex_wreg,
    input  logic            ex_wmem,
    input  logic            ex_rmem,
    input  logic [XLEN-1:0] ex_mem_addr,
    output logic            stallreq,
    output logic [XLEN-1:0] mem_wdata,
    output logic [4:0]      mem_wd,
    output logic            mem_wreg,
    output logic            mem_wmem,
    output logic            mem_rmem,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_sdata
);
    import cpu_defs::*;

    logic [XLEN-1:0] op_a, op_b, alu_res;
    logic [4:0]      shamt;
    logic [2:0]      f3;
    logic            alt;          // funct7[5]: SUB / SRA
    logic            is_md;
    logic            unused_aluop;

    assign op_a         = ex_reg1;
    assign op_b         = ex_aluop[6] ? ex_imm : ex_reg2;
    assign shamt        = op_b[4:0];
    assign f3           = ex_aluop[2:0];
    assign alt          = ex_aluop[3];
    assign is_md        = (ex_alusel == ALUSEL_MULDIV);
    assign unused_aluop = ^ex_aluop[5:4];

    always_comb begin
        alu_res = '0;
        case (ex_alusel)
            ALUSEL_LOGIC: begin
                case (f3)
                    F3_XOR:  alu_res = op_a ^ op_b;
                    F3_OR:   alu_res = op_a | op_b;
                    F3_AND:  alu_res = op_a & op_b;
                    default: alu_res = '0;
                endcase
            end
            ALUSEL_SHIFT: begin
                case (f3)
                    F3_SLL:  alu_res = op_a << shamt;
                    F3_SRL:  alu_res = alt ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
                    default: alu_res = '0;
                endcase
            end
            ALUSEL_ARITH: begin
                case (f3)
                    F3_ADD:  alu_res = alt ? (op_a - op_b) : (op_a + op_b);
                    F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                    F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
                    default: alu_res = '0;
                endcase
            end
            // load/store data moves in MEM; the address comes from ex_mem_addr
            default: alu_res = '0;
        endcase
    end

    logic            md_busy, md_done;
    logic [XLEN-1:0] md_result;

    muldiv_iter #(
        .XLEN     (XLEN),
        .MD_STEPS (MD_STEPS)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .start  (is_md & ~flush),
        .op     (f3),
        .a      (op_a),
        .b      (op_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // flush always releases the pipeline, even mid-divide
    assign stallreq = rst_n & ~flush & md_busy;

    // EX/MEM register; a stalled or flushed cycle writes a bubble
    logic            kill;
    logic [XLEN-1:0] wdata_q, wdata_d, addr_q, addr_d, sdata_q, sdata_d;
    logic [4:0]      wd_q, wd_d;
    logic            wreg_q, wreg_d, wmem_q, wmem_d, rmem_q, rmem_d;

    // a mul/div only reaches here un-stalled in DONE, so md_result is final
    assign kill = flush | stallreq | (is_md & ~md_done);

    always_comb begin
        wdata_d = '0;
        wd_d    = '0;
        wreg_d  = 1'b0;
        wmem_d  = 1'b0;
        rmem_d  = 1'b0;
        addr_d  = '0;
        sdata_d = '0;
        if (!kill) begin
            wdata_d = is_md ? md_result : alu_res;
            wd_d    = ex_wd;
            wreg_d  = ex_wreg;
            wmem_d  = ex_wmem;
            rmem_d  = ex_rmem;
            addr_d  = ex_mem_addr;
            sdata_d = ex_reg2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdata_q <= '0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wmem_q  <= 1'b0;
            rmem_q  <= 1'b0;
            addr_q  <= '0;
            sdata_q <= '0;
        end else begin
            wdata_q <= wdata_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wmem_q  <= wmem_d;
            rmem_q  <= rmem_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
        end
    end

    assign mem_wdata = wdata_q;
    assign mem_wd    = wd_q;
    assign mem_wreg  = wreg_q;
    assign mem_wmem  = wmem_q;
    assign mem_rmem  = rmem_q;
    assign mem_addr  = addr_q;
    assign mem_sdata = sdata_q;

endmodule
